// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: registered decimal digit source with prescaled auto
// stepping or debounced manual stepping, parallel load, up/down counting
// and a one-cycle carry/borrow pulse for cascading.
module bcd_digit_counter #(
  parameter int DIV        = 50,
  parameter int MAX_DIGIT  = 9,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       auto_mode,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step_btn,
  output logic [3:0] digit,
  output logic       carry,
  output logic       tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES);
  localparam logic [3:0]    MAXD       = 4'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } deb_state_t;

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_auto_q;

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_fill;
  logic          r_armed;

  deb_state_t    r_state;
  deb_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_step_set;
  logic          r_step;

  logic [3:0]    r_digit;
  logic          r_carry;
  logic          w_adv;

  assign digit = r_digit;
  assign carry = r_carry;
  assign tick  = r_tick;

  // Prescaler: runs only in auto mode with enable, tick on wrap, cleared on mode change.
  always_ff @(posedge clk) begin
    r_auto_q <= auto_mode;
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (!auto_mode || (auto_mode != r_auto_q)) begin
        r_presc <= '0;
      end else if (en) begin
        if (r_presc == PRESC_LAST) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  // Button synchronizer plus post-reset arming qualifier.
  // r_fill marks when the synchronizer holds a genuine button sample; the
  // debouncer only leaves IDLE once a released level has been seen after
  // reset, so a button held through reset cannot generate a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Debounce FSM state, counter and registered step pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_set;
    end
  end

  // Debounce FSM next-state: a level change is accepted after DEB_CYCLES stable samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + 1'b1;
    w_step_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2 && r_armed) begin
          w_state_nxt = ARM_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      ARM_PRESS: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
        end else if (w_cnt_inc == DEB_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = w_cnt_inc;
          w_step_set  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = ARM_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      ARM_RELEASE: begin
        if (r_sync2) begin
          w_state_nxt = PRESSED;
        end else if (w_cnt_inc == DEB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_adv = en & (auto_mode ? r_tick : r_step);

  // Digit register: load beats advance; carry pulses only on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (load) begin
        r_digit <= (load_val > MAXD) ? MAXD : load_val;
      end else if (w_adv) begin
        if (up_dn) begin
          if (r_digit == MAXD) begin
            r_digit <= '0;
            r_carry <= 1'b1;
          end else begin
            r_digit <= r_digit + 1'b1;
          end
        end else begin
          if (r_digit == '0) begin
            r_digit <= MAXD;
            r_carry <= 1'b1;
          end else begin
            r_digit <= r_digit - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Directed self-checking bench for bcd_digit_counter (DIV=4, MAX_DIGIT=9, DEB_CYCLES=4).
module tb_bcd_digit_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       auto_mode;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       step_btn;
  logic [3:0] digit;
  logic       carry;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] lv;
    int         exp_digit;
  } load_vec_t;

  load_vec_t lvec[7];

  bcd_digit_counter #(
    .DIV       (4),
    .MAX_DIGIT (9),
    .DEB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .auto_mode(auto_mode),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .step_btn (step_btn),
    .digit    (digit),
    .carry    (carry),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until tick is high at the sample point.
  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (tick) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_tick_seen"}, int'(seen), 1);
  endtask

  // Drive the button for n cycles and count digit changes seen meanwhile.
  task automatic btn_hold(input logic lvl, input int n, inout int changes);
    logic [3:0] prev;
    step_btn = lvl;
    for (int i = 0; i < n; i++) begin
      prev = digit;
      step();
      if (digit != prev) changes++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         changes;
    int         d_hold;
    bit         any_tick;
    logic [3:0] bounce [4];

    lvec[0] = '{4'd12, 9};
    lvec[1] = '{4'd3,  3};
    lvec[2] = '{4'd15, 9};
    lvec[3] = '{4'd9,  9};
    lvec[4] = '{4'd0,  0};
    lvec[5] = '{4'd10, 9};
    lvec[6] = '{4'd7,  7};

    bounce[0] = 4'd1;
    bounce[1] = 4'd0;
    bounce[2] = 4'd1;
    bounce[3] = 4'd0;

    rst       = 1'b1;
    en        = 1'b1;
    auto_mode = 1'b1;
    up_dn     = 1'b1;
    load      = 1'b0;
    load_val  = '0;
    step_btn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_digit", int'(digit), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_tick",  int'(tick),  0);

    // Auto up count: tick after every 4th edge, digit k after edge 4k+1.
    for (int n = 1; n <= 44; n++) begin
      step();
      chk($sformatf("up_tick_%0d", n),  int'(tick),  (n % 4 == 0) ? 1 : 0);
      chk($sformatf("up_digit_%0d", n), int'(digit), ((n - 1) / 4) % 10);
      chk($sformatf("up_carry_%0d", n), int'(carry), (n == 41) ? 1 : 0);
    end

    // Load coinciding with tick: load wins, no increment, no carry.
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    chk("ldtick_digit", int'(digit), 3);
    chk("ldtick_carry", int'(carry), 0);
    step();
    chk("ldtick_hold", int'(digit), 3);

    // Down wrap 0 -> 9 with carry, then 8, 7.
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; up_dn = 1'b0;
    chk("dn_load0", int'(digit), 0);
    wait_tick("dn1");
    step();
    chk("dn_wrap_digit", int'(digit), 9);
    chk("dn_wrap_carry", int'(carry), 1);
    step();
    chk("dn_carry_once", int'(carry), 0);
    wait_tick("dn2");
    step();
    chk("dn_8", int'(digit), 8);
    chk("dn_8_carry", int'(carry), 0);
    wait_tick("dn3");
    step();
    chk("dn_7", int'(digit), 7);

    // Load clamp table, counting frozen.
    en = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load = 1'b1; load_val = lvec[i].lv;
      step();
      load = 1'b0;
      chk($sformatf("ld_digit_%0d", i), int'(digit), lvec[i].exp_digit);
      chk($sformatf("ld_carry_%0d", i), int'(carry), 0);
      step();
      chk($sformatf("ld_hold_%0d", i), int'(digit), lvec[i].exp_digit);
    end

    // Enable gating: freeze with prescaler at 2, two valid presses ignored.
    en = 1'b1;
    wait_tick("gate");
    step();
    chk("gate_adv", int'(digit), 8);
    step();
    en = 1'b0;
    d_hold = int'(digit);
    any_tick = 1'b0;
    changes = 0;
    for (int p = 0; p < 2; p++) begin
      btn_hold(1'b1, 5, changes);
      if (tick) any_tick = 1'b1;
      btn_hold(1'b0, 5, changes);
      if (tick) any_tick = 1'b1;
    end
    chk("gate_changes", changes, 0);
    chk("gate_digit", int'(digit), 8);
    chk("gate_notick", int'(any_tick), 0);
    en = 1'b1;
    step();
    chk("resume_tick0", int'(tick), 0);
    step();
    chk("resume_tick1", int'(tick), 1);
    step();
    chk("resume_digit", int'(digit), d_hold + 1);

    // Manual mode: bounce then steady press gives exactly one step.
    auto_mode = 1'b0;
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    chk("man_load0", int'(digit), 0);
    changes = 0;
    for (int i = 0; i < 4; i++) btn_hold(bounce[i][0], 1, changes);
    btn_hold(1'b1, 10, changes);
    btn_hold(1'b0, 12, changes);
    chk("deb_changes", changes, 1);
    chk("deb_digit", int'(digit), 1);
    changes = 0;
    btn_hold(1'b1, 3, changes);
    btn_hold(1'b0, 10, changes);
    chk("short_changes", changes, 0);
    chk("short_digit", int'(digit), 1);

    // Reset with digit=7 and button held (FSM in PRESSED).
    load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0;
    chk("mid_load6", int'(digit), 6);
    step_btn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (digit == 4'd7) break;
      step();
    end
    chk("mid_digit7", int'(digit), 7);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_digit", int'(digit), 0);
    chk("mid_rst_carry", int'(carry), 0);
    chk("mid_rst_tick",  int'(tick),  0);
    changes = 0;
    btn_hold(1'b1, 12, changes);
    chk("held_no_step", changes, 0);
    chk("held_digit", int'(digit), 0);
    btn_hold(1'b0, 8, changes);
    btn_hold(1'b1, 8, changes);
    btn_hold(1'b0, 8, changes);
    chk("repress_changes", changes, 1);
    chk("repress_digit", int'(digit), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
